// File: rtl/alu_div_pkg.sv
// Shared types and sizing for the iterative ALU divider.
package alu_div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } div_state_t;
endpackage

// File: rtl/adder.sv
// Ripple-free behavioural adder/subtractor; sign is the result MSB.
// Latency: combinational. Backpressure: none (pure function of inputs).
// With invert_i_2 set it computes i_1 - i_2 in two's complement.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_1,
  input  logic [WIDTH-1:0] i_2,
  input  logic             invert_i_2,
  input  logic             enable,
  output logic [WIDTH-1:0] sum,
  output logic             sign
);
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] cin;

  assign b_eff = invert_i_2 ? ~i_2 : i_2;
  assign cin   = {{(WIDTH-1){1'b0}}, invert_i_2};
  assign sum   = enable ? (i_1 + b_eff + cin) : '0;
  assign sign  = sum[WIDTH-1];
endmodule

// File: rtl/alu_divider.sv
// Restoring signed/unsigned divider, one quotient bit per cycle via adder.
// Latency: WIDTH+2 cycles from acceptance to out_valid (2 for divide by zero).
// Backpressure: result held in DONE until out_ready; no new operands until IDLE.
module alu_divider
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t state_q, state_d;

  logic [WIDTH-1:0] dvd_r, dvs_r;
  logic             sgn_r;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] q_work;
  logic [CW-1:0]    cnt;
  logic             q_neg, r_neg;

  logic             dvs_zero;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             diff_neg;

  assign dvs_zero    = (dvs_r == '0);
  assign start_ready = (state_q == IDLE);

  // Remainder below the divisor always fits WIDTH bits; the extra top bit
  // only carries the shifted-in value so a 2^(WIDTH-1) magnitude cannot wrap.
  assign shifted = {prem[WIDTH-1:0], a_mag[WIDTH-1]};

  adder #(
    .WIDTH(WIDTH + 1)
  ) u_trial_sub (
    .i_1       (shifted),
    .i_2       ({1'b0, b_mag}),
    .invert_i_2(1'b1),
    .enable    (1'b1),
    .sum       (diff),
    .sign      (diff_neg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Divide-by-zero results are loaded in PREP and pass through FIX untouched.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_valid) state_d = PREP;
      PREP: state_d = dvs_zero ? FIX : CALC;
      CALC: if (cnt == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_r       <= '0;
      dvs_r       <= '0;
      sgn_r       <= 1'b0;
      a_mag       <= '0;
      b_mag       <= '0;
      prem        <= '0;
      q_work      <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            dvd_r <= dividend;
            dvs_r <= divisor;
            sgn_r <= is_signed;
          end
        end
        PREP: begin
          a_mag       <= (sgn_r && dvd_r[WIDTH-1]) ? -dvd_r : dvd_r;
          b_mag       <= (sgn_r && dvs_r[WIDTH-1]) ? -dvs_r : dvs_r;
          q_neg       <= sgn_r && (dvd_r[WIDTH-1] ^ dvs_r[WIDTH-1]);
          r_neg       <= sgn_r && dvd_r[WIDTH-1];
          prem        <= '0;
          q_work      <= '0;
          cnt         <= CNT_LOAD;
          overflow    <= 1'b0;
          div_by_zero <= dvs_zero;
          if (dvs_zero) begin
            quotient  <= '1;
            remainder <= dvd_r;
          end
        end
        CALC: begin
          a_mag <= {a_mag[WIDTH-2:0], 1'b0};
          cnt   <= cnt - 1'b1;
          if (diff_neg) begin
            prem   <= shifted;
            q_work <= {q_work[WIDTH-2:0], 1'b0};
          end else begin
            prem   <= diff;
            q_work <= {q_work[WIDTH-2:0], 1'b1};
          end
        end
        FIX: begin
          if (!div_by_zero) begin
            quotient  <= q_neg ? -q_work : q_work;
            remainder <= r_neg ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
            overflow  <= sgn_r && (dvd_r == MIN_NEG) && (dvs_r == '1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
